// File: rtl/wave_mem_loader_if.sv
// Byte-stream and wave-memory write bus for the wave memory loader.
//   byte_data_in/byte_valid_in/byte_ready_out : host byte stream (valid/ready)
//   mem_write_addr_out/data_out/en_out        : wave memory write port
// slave  : loader side (consumes bytes, drives memory writes)
// master : host/memory side
interface wave_mem_loader_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [7:0]        byte_data_in;
    logic              byte_valid_in;
    logic              byte_ready_out;
    logic [ADDR_W-1:0] mem_write_addr_out;
    logic [3:0]        mem_write_data_out;
    logic              mem_write_en_out;

    modport slave (
        input  byte_data_in,
        input  byte_valid_in,
        output byte_ready_out,
        output mem_write_addr_out,
        output mem_write_data_out,
        output mem_write_en_out
    );

    modport master (
        output byte_data_in,
        output byte_valid_in,
        input  byte_ready_out,
        input  mem_write_addr_out,
        input  mem_write_data_out,
        input  mem_write_en_out
    );
endinterface

// File: rtl/wave_mem_loader.sv
// Wave memory loader: unpacks host bytes into 4-bit samples and writes them
// sequentially into the tone generator's wave memory from a base address.
// Ports:
//   clk_in, reset_in (sync, active-high)
//   load_start_in, load_base_in, load_count_in : load request (sampled in IDLE)
//   busy_out, done_out                         : load status (registered)
//   bus (slave modport)                        : byte stream + memory write port
module wave_mem_loader #(
    parameter int unsigned ADDR_W   = 5,
    parameter bit          HI_FIRST = 1'b1
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              load_start_in,
    input  logic [ADDR_W-1:0] load_base_in,
    input  logic [ADDR_W:0]   load_count_in,
    output logic              busy_out,
    output logic              done_out,
    wave_mem_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        WR_A      = 3'd2,
        WR_B      = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_r, addr_d;
    logic [CNT_W-1:0]  remain_r, remain_d;
    logic [7:0]        byte_r, byte_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]        wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  eff_count_c;

    // Zero or oversized counts mean "fill the whole table".
    always_comb begin
        eff_count_c = load_count_in;
        if (load_count_in == '0 || load_count_in > CNT_W'(DEPTH)) begin
            eff_count_c = CNT_W'(DEPTH);
        end
    end

    // Next-state, datapath and registered-output precompute.
    // Outputs are computed for the state being entered so they appear in it.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_r;
        remain_d  = remain_r;
        byte_d    = byte_r;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start_in) begin
                    state_d  = WAIT_BYTE;
                    addr_d   = load_base_in;
                    remain_d = eff_count_c;
                end
            end
            WAIT_BYTE: begin
                if (bus.byte_valid_in && ready_q) begin
                    state_d = WR_A;
                    byte_d  = bus.byte_data_in;
                end
            end
            WR_A:    state_d = (remain_r == '0) ? FINISH : WR_B;
            WR_B:    state_d = (remain_r == '0) ? FINISH : WAIT_BYTE;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Write issue: the first nibble comes straight from the accepted byte.
        if (state_d == WR_A) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_r;
            wr_data_d = HI_FIRST ? bus.byte_data_in[7:4] : bus.byte_data_in[3:0];
            addr_d    = addr_r + ADDR_W'(1);
            remain_d  = remain_r - CNT_W'(1);
        end else if (state_d == WR_B) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_r;
            wr_data_d = HI_FIRST ? byte_r[3:0] : byte_r[7:4];
            addr_d    = addr_r + ADDR_W'(1);
            remain_d  = remain_r - CNT_W'(1);
        end

        ready_d = (state_d == WAIT_BYTE);
        busy_d  = (state_d == WAIT_BYTE) || (state_d == WR_A) || (state_d == WR_B);
        done_d  = (state_d == FINISH);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            addr_r    <= '0;
            remain_r  <= '0;
            byte_r    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_r    <= addr_d;
            remain_r  <= remain_d;
            byte_r    <= byte_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.byte_ready_out     = ready_q;
    assign bus.mem_write_addr_out = wr_addr_q;
    assign bus.mem_write_data_out = wr_data_q;
    assign bus.mem_write_en_out   = wr_en_q;
    assign busy_out               = busy_q;
    assign done_out               = done_q;
endmodule

// File: tb/tb_wave_mem_loader.sv
// Scoreboard bench for wave_mem_loader: stimulus pushes expected writes and
// done markers; a negedge monitor pops and compares whenever the DUT strobes.
module tb_wave_mem_loader;
    typedef struct packed {
        logic       is_done;
        logic [4:0] addr;
        logic [3:0] data;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       reset_in;
    logic       load_start_in;
    logic [4:0] load_base_in;
    logic [5:0] load_count_in;
    logic       busy_out;
    logic       done_out;

    wave_mem_loader_if #(.ADDR_W(5)) bus ();

    wave_mem_loader #(.ADDR_W(5), .HI_FIRST(1'b1)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .load_start_in (load_start_in),
        .load_base_in  (load_base_in),
        .load_count_in (load_count_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .bus           (bus)
    );

    always #5 clk_in = ~clk_in;

    exp_t       exp_q[$];
    logic [7:0] tx_bytes[$];
    int         passed = 0;
    int         total = 0;
    int         wr_seen = 0;
    int         done_seen = 0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk_in) begin
        if (mon_en && !reset_in) begin
            if (bus.mem_write_en_out) begin
                exp_t e;
                wr_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.mem_write_addr_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_not_done", 32'(e.is_done), 32'd0);
                    check("write_addr", 32'(bus.mem_write_addr_out), 32'(e.addr));
                    check("write_data", 32'(bus.mem_write_data_out), 32'(e.data));
                end
                check("ready_during_write", 32'(bus.byte_ready_out), 32'd0);
                check("busy_during_write", 32'(busy_out), 32'd1);
            end
            if (done_out) begin
                exp_t e;
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_in_order", 32'(e.is_done), 32'd1);
                end
                check("busy_at_done", 32'(busy_out), 32'd0);
            end
        end
    end

    task automatic do_start(input logic [4:0] base, input logic [5:0] cnt);
        @(negedge clk_in);
        load_start_in = 1'b1;
        load_base_in  = base;
        load_count_in = cnt;
        @(negedge clk_in);
        load_start_in = 1'b0;
        load_base_in  = 5'd0;
        load_count_in = 6'd0;
        check("busy_after_start", 32'(busy_out), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        @(negedge clk_in);
        bus.byte_valid_in = 1'b1;
        bus.byte_data_in  = b;
        for (int i = 0; i < 200; i++) begin
            if (bus.byte_ready_out) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clk_in);
        #1;
        bus.byte_valid_in = 1'b0;
        bus.byte_data_in  = 8'h00;
    endtask

    task automatic wait_done(input int prev);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (done_seen > prev) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk_in);
        check("busy_after_done", 32'(busy_out), 32'd0);
        check("done_single_pulse", 32'(done_out), 32'd0);
    endtask

    // One full load: expectations from tx_bytes, optional valid gaps and a
    // stray start pulse (with different parameters) in the middle.
    task automatic run_load(input logic [4:0] base, input logic [5:0] cnt,
                            input int gap, input bit stray_start);
        int         eff;
        int         nbytes;
        int         prev_done;
        logic [4:0] a;
        logic [7:0] b;
        eff = (cnt == 0 || cnt > 6'd32) ? 32 : int'(cnt);
        a = base;
        for (int k = 0; k < eff; k++) begin
            b = tx_bytes[k / 2];
            exp_q.push_back('{1'b0, a, (k % 2 == 0) ? b[7:4] : b[3:0]});
            a = a + 5'd1;
        end
        exp_q.push_back('{1'b1, 5'd0, 4'd0});
        prev_done = done_seen;
        nbytes = (eff + 1) / 2;
        do_start(base, cnt);
        for (int j = 0; j < nbytes; j++) begin
            send_byte(tx_bytes[j]);
            if (j == nbytes - 1) begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk_in);
                    check("ready_low_after_last", 32'(bus.byte_ready_out), 32'd0);
                end
            end else begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk_in);
                    bus.byte_data_in = 8'(g * 37 + 5);
                    bus.byte_valid_in = (g == 1);
                    load_start_in = stray_start && (g == 2);
                    load_base_in  = 5'd7;
                    load_count_in = 6'd2;
                end
                load_start_in = 1'b0;
                bus.byte_valid_in = 1'b0;
            end
        end
        wait_done(prev_done);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        bit seen;
        reset_in = 1'b1;
        load_start_in = 1'b1;
        load_base_in = 5'd9;
        load_count_in = 6'd4;
        bus.byte_valid_in = 1'b1;
        bus.byte_data_in = 8'hFF;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", 32'(bus.byte_ready_out), 32'd0);
        check("rst_en", 32'(bus.mem_write_en_out), 32'd0);
        check("rst_addr", 32'(bus.mem_write_addr_out), 32'd0);
        check("rst_data", 32'(bus.mem_write_data_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        load_start_in = 1'b0;
        bus.byte_valid_in = 1'b0;
        bus.byte_data_in = 8'h00;
        load_base_in = 5'd0;
        load_count_in = 6'd0;
        @(posedge clk_in);
        #1 reset_in = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_in);
        check("idle_busy", 32'(busy_out), 32'd0);

        // Basic load.
        tx_bytes = '{8'hA5, 8'h3C};
        run_load(5'd0, 6'd4, 0, 1'b0);

        // Odd count with wrap.
        tx_bytes = '{8'h12, 8'h34};
        run_load(5'd31, 6'd3, 0, 1'b0);

        // Full table via count 0, then clamped oversized count from base 5.
        tx_bytes.delete();
        for (int k = 0; k < 16; k++) tx_bytes.push_back({4'((2 * k) % 16), 4'((2 * k + 1) % 16)});
        prev = wr_seen;
        run_load(5'd0, 6'd0, 0, 1'b0);
        check("full_strobe_count", 32'(wr_seen - prev), 32'd32);
        prev = wr_seen;
        run_load(5'd5, 6'd40, 0, 1'b0);
        check("clamp_strobe_count", 32'(wr_seen - prev), 32'd32);

        // Backpressure gaps with a stray start mid-load.
        tx_bytes = '{8'hA5, 8'h3C, 8'h96};
        run_load(5'd12, 6'd6, 5, 1'b1);

        // Reset mid-load after the second write of a count 8 load.
        tx_bytes = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        exp_q.push_back('{1'b0, 5'd20, 4'h5});
        exp_q.push_back('{1'b0, 5'd21, 4'hA});
        prev = wr_seen;
        do_start(5'd20, 6'd8);
        send_byte(8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            if (wr_seen - prev >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("mid_load_writes", 32'(seen), 32'd1);
        @(posedge clk_in);
        #1 reset_in = 1'b1;
        prev = done_seen;
        @(posedge clk_in);
        #1 reset_in = 1'b0;
        @(negedge clk_in);
        check("midrst_ready", 32'(bus.byte_ready_out), 32'd0);
        check("midrst_en", 32'(bus.mem_write_en_out), 32'd0);
        check("midrst_addr", 32'(bus.mem_write_addr_out), 32'd0);
        check("midrst_data", 32'(bus.mem_write_data_out), 32'd0);
        check("midrst_busy", 32'(busy_out), 32'd0);
        repeat (4) @(negedge clk_in);
        check("midrst_no_done", 32'(done_seen - prev), 32'd0);

        // Fresh load after the abort.
        tx_bytes = '{8'h7E, 8'h81};
        run_load(5'd2, 6'd4, 0, 1'b0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
